// File: rtl/pe_pkg.sv
// Shared types for the PE dispatcher: FSM states, default feature vector, coordinate widths.
// Fallback geometry macros are defined here so every file sees the same defaults.
`ifndef IA_ROW
`define IA_ROW 8
`endif
`ifndef IA_COL
`define IA_COL 8
`endif
`ifndef IA_CHANNEL
`define IA_CHANNEL 4
`endif
`ifndef IA_DATA_BITWIDTH
`define IA_DATA_BITWIDTH 8
`endif

package pe_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_OUT,
    S_DONE
  } state_e;

  // Coordinates need one extra bit so a count can hold the full size itself.
  localparam int unsigned DEF_ROW_W  = $clog2(`IA_ROW) + 1;
  localparam int unsigned DEF_COL_W  = $clog2(`IA_COL) + 1;
  localparam int unsigned DEF_LANES  = 3 * `IA_CHANNEL;
  localparam int unsigned DEF_DATA_W = `IA_DATA_BITWIDTH;

  typedef logic signed [DEF_DATA_W-1:0] feature_t [0:DEF_LANES-1];

  function automatic int unsigned coord_w(input int unsigned n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/pe_dispatcher_if.sv
// Result stream from the dispatcher to the output-feature writer (valid/ready with row/col tags).
interface pe_dispatcher_if
  import pe_pkg::*;
#(
  parameter int unsigned ROW_W  = DEF_ROW_W,
  parameter int unsigned COL_W  = DEF_COL_W,
  parameter int unsigned LANES  = DEF_LANES,
  parameter int unsigned DATA_W = DEF_DATA_W
);
  logic                     out_valid;
  logic                     out_ready;
  logic [ROW_W-1:0]         out_h;
  logic [COL_W-1:0]         out_w;
  logic signed [DATA_W-1:0] out_feature [0:LANES-1];

  modport master (
    output out_valid,
    output out_h,
    output out_w,
    output out_feature,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_h,
    input  out_w,
    input  out_feature,
    output out_ready
  );
endinterface

// File: rtl/pe_raster_cnt.sv
// Row-major (h, w) raster counter; sizes are clamped to the array geometry when loaded.
module pe_raster_cnt
  import pe_pkg::*;
#(
  parameter int unsigned IA_ROW = 8,
  parameter int unsigned IA_COL = 8,
  localparam int unsigned ROW_W = coord_w(IA_ROW),
  localparam int unsigned COL_W = coord_w(IA_COL)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [ROW_W-1:0] i_rows,
  input  logic [COL_W-1:0] i_cols,
  input  logic             i_adv,
  output logic [ROW_W-1:0] o_h,
  output logic [COL_W-1:0] o_w,
  output logic             o_last
);
  logic [ROW_W-1:0] r_rows, r_h, w_rows_clamp;
  logic [COL_W-1:0] r_cols, r_w, w_cols_clamp;
  logic             w_row_end;

  assign w_rows_clamp = (i_rows > ROW_W'(IA_ROW)) ? ROW_W'(IA_ROW) : i_rows;
  assign w_cols_clamp = (i_cols > COL_W'(IA_COL)) ? COL_W'(IA_COL) : i_cols;
  assign w_row_end    = (r_w == r_cols - COL_W'(1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rows <= '0;
      r_cols <= '0;
      r_h    <= '0;
      r_w    <= '0;
    end else if (i_load) begin
      r_rows <= w_rows_clamp;
      r_cols <= w_cols_clamp;
      r_h    <= '0;
      r_w    <= '0;
    end else if (i_adv) begin
      if (w_row_end) begin
        r_w <= '0;
        r_h <= r_h + ROW_W'(1);
      end else begin
        r_w <= r_w + COL_W'(1);
      end
    end
  end

  assign o_h    = r_h;
  assign o_w    = r_w;
  assign o_last = w_row_end && (r_h == r_rows - ROW_W'(1));
endmodule

// File: rtl/pe_dispatcher.sv
// Walks an (h, w) raster, starts the PE per position and streams each captured result downstream.
// Optional PE_TIMEOUT_EN adds a watchdog on the PE finish that aborts the run with a sticky error.
`ifndef IA_ROW
`define IA_ROW 8
`endif
`ifndef IA_COL
`define IA_COL 8
`endif
`ifndef IA_CHANNEL
`define IA_CHANNEL 4
`endif
`ifndef IA_DATA_BITWIDTH
`define IA_DATA_BITWIDTH 8
`endif

module pe_dispatcher
  import pe_pkg::*;
#(
  parameter int unsigned IA_ROW           = `IA_ROW,
  parameter int unsigned IA_COL           = `IA_COL,
  parameter int unsigned IA_CHANNEL       = `IA_CHANNEL,
  parameter int unsigned IA_DATA_BITWIDTH = `IA_DATA_BITWIDTH,
  parameter int unsigned TIMEOUT_CYCLES   = 1024,
  localparam int unsigned ROW_W = coord_w(IA_ROW),
  localparam int unsigned COL_W = coord_w(IA_COL),
  localparam int unsigned LANES = 3 * IA_CHANNEL
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic                               i_start,
  input  logic [ROW_W-1:0]                   i_rows,
  input  logic [COL_W-1:0]                   i_cols,
  output logic                               o_busy,
  output logic                               o_done,
  output logic                               o_error,
  output logic                               o_pe_start,
  output logic [ROW_W-1:0]                   o_pe_ia_h,
  output logic [COL_W-1:0]                   o_pe_ia_w,
  input  logic                               i_pe_finish,
  input  logic signed [IA_DATA_BITWIDTH-1:0] i_pe_feature [0:LANES-1],
  pe_dispatcher_if.master                    o_out
);
  state_e           r_state, w_state_next;
  logic             r_first;
  logic             w_start_idle, w_size_zero, w_load, w_accept, w_hs, w_adv, w_last, w_timeout;
  logic [ROW_W-1:0] r_out_h;
  logic [COL_W-1:0] r_out_w;
  logic signed [IA_DATA_BITWIDTH-1:0] r_out_feature [0:LANES-1];

  assign w_start_idle = (r_state == S_IDLE) && i_start;
  assign w_size_zero  = (i_rows == '0) || (i_cols == '0);
  assign w_load       = w_start_idle && !w_size_zero;
  // The first S_WAIT cycle may still show a stale finish from the previous position.
  assign w_accept     = (r_state == S_WAIT) && !r_first && i_pe_finish;
  assign w_hs         = (r_state == S_OUT) && o_out.out_ready;
  assign w_adv        = w_hs && !w_last;

  pe_raster_cnt #(
    .IA_ROW(IA_ROW),
    .IA_COL(IA_COL)
  ) u_raster (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_load(w_load),
    .i_rows(i_rows),
    .i_cols(i_cols),
    .i_adv (w_adv),
    .o_h   (o_pe_ia_h),
    .o_w   (o_pe_ia_w),
    .o_last(w_last)
  );

`ifdef PE_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] r_wdog;
  logic            r_error;

  assign w_timeout = (r_state == S_WAIT) && !w_accept && (r_wdog == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wdog <= '0;
    end else if (r_state == S_START) begin
      r_wdog <= '0;
    end else if (r_state == S_WAIT) begin
      r_wdog <= r_wdog + WD_W'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_error <= 1'b0;
    end else if (w_start_idle) begin
      r_error <= 1'b0;
    end else if (w_timeout) begin
      r_error <= 1'b1;
    end
  end

  assign o_error = r_error;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT_CYCLES;
  assign w_timeout        = 1'b0;
  assign o_error          = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:  if (i_start) w_state_next = w_size_zero ? S_DONE : S_START;
      S_START: w_state_next = S_WAIT;
      S_WAIT: begin
        if (w_accept) begin
          w_state_next = S_OUT;
        end else if (w_timeout) begin
          w_state_next = S_DONE;
        end
      end
      S_OUT:   if (w_hs) w_state_next = w_last ? S_DONE : S_START;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_busy          = (r_state != S_IDLE);
    o_done          = (r_state == S_DONE);
    o_pe_start      = (r_state == S_START);
    o_out.out_valid = (r_state == S_OUT);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_first <= 1'b0;
    end else begin
      r_first <= (r_state == S_START);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_out_h       <= '0;
      r_out_w       <= '0;
      r_out_feature <= '{default: '0};
    end else if (w_accept) begin
      r_out_h       <= o_pe_ia_h;
      r_out_w       <= o_pe_ia_w;
      r_out_feature <= i_pe_feature;
    end
  end

  assign o_out.out_h       = r_out_h;
  assign o_out.out_w       = r_out_w;
  assign o_out.out_feature = r_out_feature;
endmodule
